operand_fetch: RTL

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/operand_fetch_if.sv | 31 +++
 rtl/operand_fetch.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/operand_fetch_if.sv
// Operand-fetch bus: instruction in, ALU operand bundle out, register writeback in.
interface operand_fetch_if;
  localparam int unsigned XLEN = 16;
  localparam int unsigned RW   = 3;

  logic            in_valid;
  logic [XLEN-1:0] in_instr;
  logic            in_ready;
  logic            out_valid;
  logic            out_ready;
  logic [2:0]      out_op;
  logic [XLEN-1:0] out_a;
  logic [XLEN-1:0] out_b;
  logic [RW-1:0]   out_dr;
  logic            wb_en;
  logic [RW-1:0]   wb_dr;
  logic [XLEN-1:0] wb_data;
  logic [2:0]      wb_cc;
  logic [2:0]      cc;
  logic            illegal;

  modport slave (
    input  in_valid, in_instr, out_ready, wb_en, wb_dr, wb_data, wb_cc,
    output in_ready, out_valid, out_op, out_a, out_b, out_dr, cc, illegal
  );

  modport master (
    output in_valid, in_instr, out_ready, wb_en, wb_dr, wb_data, wb_cc,
    input  in_ready, out_valid, out_op, out_a, out_b, out_dr, cc, illegal
  );
endinterface

// File: rtl/operand_fetch.sv
// LC-3b operand fetch: decode, scoreboard hazard stall, writeback bypass and a
// one-entry ALU operand output register.
module operand_fetch (
  input  logic          clk,
  input  logic          reset,
  operand_fetch_if.slave bus
);
  localparam int unsigned XLEN = 16;
  localparam int unsigned RN   = 8;
  localparam int unsigned RW   = 3;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_AND   = 3'd1;
  localparam logic [2:0] OP_XOR   = 3'd2;
  localparam logic [2:0] OP_LSHF  = 3'd3;
  localparam logic [2:0] OP_RSHFL = 3'd4;
  localparam logic [2:0] OP_RSHFA = 3'd5;

  logic [XLEN-1:0] r_rf [RN];
  logic [RN-1:0]   r_pending;
  logic            r_out_valid;
  logic [2:0]      r_out_op;
  logic [XLEN-1:0] r_out_a;
  logic [XLEN-1:0] r_out_b;
  logic [RW-1:0]   r_out_dr;
  logic [2:0]      r_cc;
  logic            r_illegal;

  logic [3:0]      w_opc;
  logic [RW-1:0]   w_dr;
  logic [RW-1:0]   w_sr1;
  logic [RW-1:0]   w_sr2;
  logic            w_legal;
  logic            w_is_shf;
  logic            w_sr2_used;
  logic [2:0]      w_op;
  logic            w_byp1;
  logic            w_byp2;
  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b;
  logic            w_hz1;
  logic            w_hz2;
  logic            w_stall;
  logic            w_in_ready;
  logic            w_accept;
  logic [RN-1:0]   w_pending_nxt;

  assign w_opc = bus.in_instr[15:12];
  assign w_dr  = bus.in_instr[11:9];
  assign w_sr1 = bus.in_instr[8:6];
  assign w_sr2 = bus.in_instr[2:0];

  // Decode opcode and shift sub-op
  always_comb begin
    w_legal    = 1'b0;
    w_is_shf   = 1'b0;
    w_sr2_used = 1'b0;
    w_op       = OP_ADD;
    case (w_opc)
      4'b0001: begin w_legal = 1'b1; w_sr2_used = !bus.in_instr[5]; w_op = OP_ADD; end
      4'b0101: begin w_legal = 1'b1; w_sr2_used = !bus.in_instr[5]; w_op = OP_AND; end
      4'b1001: begin w_legal = 1'b1; w_sr2_used = !bus.in_instr[5]; w_op = OP_XOR; end
      4'b1101: begin
        w_is_shf = 1'b1;
        case (bus.in_instr[5:4])
          2'b00:   begin w_legal = 1'b1; w_op = OP_LSHF;  end
          2'b01:   begin w_legal = 1'b1; w_op = OP_RSHFL; end
          2'b11:   begin w_legal = 1'b1; w_op = OP_RSHFA; end
          default: w_legal = 1'b0;
        endcase
      end
      default: w_legal = 1'b0;
    endcase
  end

  // Register reads with same-cycle writeback bypass
  assign w_byp1 = bus.wb_en && (bus.wb_dr == w_sr1);
  assign w_byp2 = bus.wb_en && (bus.wb_dr == w_sr2);
  assign w_a    = w_byp1 ? bus.wb_data : r_rf[w_sr1];

  always_comb begin
    w_b = w_byp2 ? bus.wb_data : r_rf[w_sr2];
    if (w_is_shf)
      w_b = {12'd0, bus.in_instr[3:0]};
    else if (bus.in_instr[5])
      w_b = {{11{bus.in_instr[4]}}, bus.in_instr[4:0]};
  end

  // A writeback landing this cycle resolves the hazard on that register
  assign w_hz1      = r_pending[w_sr1] && !w_byp1;
  assign w_hz2      = w_sr2_used && r_pending[w_sr2] && !w_byp2;
  assign w_stall    = bus.in_valid && w_legal && (w_hz1 || w_hz2);
  assign w_in_ready = (!r_out_valid || bus.out_ready) && !w_stall;
  assign w_accept   = bus.in_valid && w_in_ready;

  // Writeback clears first so a same-cycle issue to the same DR keeps it pending
  always_comb begin
    w_pending_nxt = r_pending;
    if (bus.wb_en)
      w_pending_nxt[bus.wb_dr] = 1'b0;
    if (w_accept && w_legal)
      w_pending_nxt[w_dr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RN; i++) r_rf[i] <= '0;
      r_pending   <= '0;
      r_out_valid <= 1'b0;
      r_out_op    <= '0;
      r_out_a     <= '0;
      r_out_b     <= '0;
      r_out_dr    <= '0;
      r_cc        <= 3'b010;
      r_illegal   <= 1'b0;
    end else begin
      if (bus.wb_en) begin
        r_rf[bus.wb_dr] <= bus.wb_data;
        r_cc            <= bus.wb_cc;
      end
      r_pending <= w_pending_nxt;
      r_illegal <= w_accept && !w_legal;
      if (w_accept && w_legal) begin
        r_out_valid <= 1'b1;
        r_out_op    <= w_op;
        r_out_a     <= w_a;
        r_out_b     <= w_b;
        r_out_dr    <= w_dr;
      end else if (r_out_valid && bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_op    = r_out_op;
  assign bus.out_a     = r_out_a;
  assign bus.out_b     = r_out_b;
  assign bus.out_dr    = r_out_dr;
  assign bus.cc        = r_cc;
  assign bus.illegal   = r_illegal;
endmodule
